fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 110 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that locks one requester onto a shared async-FIFO write
// port for a whole packet, with a forced release after MAXB words.
//
//   state | meaning
//   IDLE  | no owner; pick next requester round-robin from last_owner+1
//   LOCK  | packet locked to r_owner; words pass while req[owner] & ~wfull
module fifo_wr_arbiter #(
  parameter int N    = 4,
  parameter int DW   = 8,
  parameter int MAXB = 16,
  localparam int OW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset_b,
  input  logic [N-1:0]    i_req,
  input  logic [N*DW-1:0] i_data,
  input  logic [N-1:0]    i_last,
  input  logic            i_wfull,
  output logic [N-1:0]    o_ack,
  output logic            o_winc,
  output logic [DW-1:0]   o_wdata,
  output logic [OW-1:0]   o_owner,
  output logic            o_busy,
  output logic            o_overrun
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t        r_state;
  logic [OW-1:0] r_owner;
  logic [OW-1:0] r_last_owner;
  logic [7:0]    r_cnt;
  logic          r_overrun;

  logic [OW-1:0] w_pick;
  logic [OW:0]   w_sum;
  logic          w_winc;
  logic          w_owner_last;
  logic [7:0]    w_cnt_next;
  logic          w_at_max;

  // Scan from farthest to nearest so the nearest requester after last_owner wins.
  always_comb begin
    w_pick = r_last_owner;
    w_sum  = '0;
    for (int k = N; k >= 1; k--) begin
      w_sum = {1'b0, r_last_owner} + (OW+1)'(k);
      if (w_sum >= (OW+1)'(N)) w_sum = w_sum - (OW+1)'(N);
      if (i_req[w_sum[OW-1:0]]) w_pick = w_sum[OW-1:0];
    end
  end

  assign w_winc       = (r_state == LOCK) && i_req[r_owner] && !i_wfull;
  assign w_owner_last = i_last[r_owner];
  assign w_cnt_next   = r_cnt + 8'd1;
  assign w_at_max     = (w_cnt_next == 8'(MAXB));

  always_comb begin
    o_ack = '0;
    if (w_winc) o_ack[r_owner] = 1'b1;
  end

  always_comb begin
    o_wdata = '0;
    if (r_state == LOCK) o_wdata = i_data[int'(r_owner)*DW +: DW];
  end

  assign o_winc    = w_winc;
  assign o_owner   = r_owner;
  assign o_busy    = (r_state == LOCK);
  assign o_overrun = r_overrun;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_owner <= OW'(N-1);
      r_cnt        <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|i_req) begin
            r_owner <= w_pick;
            r_cnt   <= '0;
            r_state <= LOCK;
          end
        end
        LOCK: begin
          if (w_winc) begin
            if (w_owner_last) begin
              r_state      <= IDLE;
              r_last_owner <= r_owner;
            end else if (w_at_max) begin
              // End-of-packet on the MAXBth word takes the branch above, so no overrun then.
              r_state      <= IDLE;
              r_last_owner <= r_owner;
              r_overrun    <= 1'b1;
            end else begin
              r_cnt <= w_cnt_next;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed + random bench for fifo_wr_arbiter: cycle model for all outputs and
// per-requester word queues for ordering.
module tb_fifo_wr_arbiter;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;
  localparam int OW   = 2;

  logic            clk = 1'b0;
  logic            reset_b = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    last = '0;
  logic [N*DW-1:0] data = '0;
  logic            wfull = 1'b0;
  logic [N-1:0]    o_ack;
  logic            o_winc;
  logic [DW-1:0]   o_wdata;
  logic [OW-1:0]   o_owner;
  logic            o_busy;
  logic            o_overrun;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N(N), .DW(DW), .MAXB(MAXB)) dut (
    .clk(clk), .reset_b(reset_b), .i_req(req), .i_data(data), .i_last(last),
    .i_wfull(wfull), .o_ack(o_ack), .o_winc(o_winc), .o_wdata(o_wdata),
    .o_owner(o_owner), .o_busy(o_busy), .o_overrun(o_overrun)
  );

  bit            m_state;
  int            m_owner, m_lo, m_cnt;
  bit            m_ovr;
  logic          e_winc;
  logic [N-1:0]  e_ack;

  logic [DW-1:0] q[N][$];
  logic [5:0]    seq[N];
  bit            keep[N];
  bit            rnd;
  bit            p_busy;
  logic [N-1:0]  snap;
  int            waitc[N];
  int            grants[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 1'b0; m_owner = 0; m_lo = N-1; m_cnt = 0; m_ovr = 1'b0;
    e_winc = 1'b0; e_ack = '0;
  endtask

  task automatic check();
    logic [DW-1:0] e_wd;
    logic [DW-1:0] w;
    int o;
    e_winc = m_state && req[m_owner] && !wfull;
    e_ack = '0;
    if (e_winc) e_ack[m_owner] = 1'b1;
    e_wd = m_state ? data[m_owner*DW +: DW] : '0;
    chk("busy", o_busy, m_state);
    chk("owner", o_owner, m_owner);
    chk("overrun", o_overrun, m_ovr);
    chk("ack", o_ack, e_ack);
    chk("winc", o_winc, e_winc);
    chk("wdata", o_wdata, e_wd);
    chk("ack_onehot", $countones(o_ack) <= 1, 1);
    chk("winc_while_full", o_winc & wfull, 0);
    chk("ack_or_eq_winc", |o_ack, o_winc);
    if (o_winc === 1'b1) begin
      o = int'(o_owner);
      if (q[o].size() == 0) chk("sb_empty", q[o].size(), 1);
      else begin
        w = q[o].pop_front();
        chk("sb_order", o_wdata, w);
      end
    end
    if (o_busy === 1'b1 && !p_busy) begin
      grants.push_back(int'(o_owner));
      for (int i = 0; i < N; i++) begin
        if (i == int'(o_owner) || !snap[i]) waitc[i] = 0;
        else begin
          waitc[i]++;
          chk("starvation", waitc[i] < N, 1);
        end
      end
    end
    p_busy = (o_busy === 1'b1);
    snap = req;
  endtask

  task automatic model_step();
    bit found;
    int idx;
    if (!reset_b) model_reset();
    else if (!m_state) begin
      m_ovr = 1'b0;
      if (|req) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          idx = (m_lo + k) % N;
          if (!found && req[idx]) begin m_owner = idx; found = 1'b1; end
        end
        m_cnt = 0;
        m_state = 1'b1;
      end
    end else begin
      m_ovr = 1'b0;
      if (e_winc) begin
        if (last[m_owner]) begin m_state = 1'b0; m_lo = m_owner; end
        else if (m_cnt + 1 == MAXB) begin m_state = 1'b0; m_lo = m_owner; m_ovr = 1'b1; end
        else m_cnt++;
      end
    end
  endtask

  task automatic present(input int i, input bit l);
    data[i*DW +: DW] = {2'(i), seq[i]};
    q[i].push_back({2'(i), seq[i]});
    req[i] = 1'b1;
    last[i] = l;
  endtask

  task automatic withdraw(input int i);
    req[i] = 1'b0;
    if (q[i].size() > 0) void'(q[i].pop_back());
  endtask

  task automatic advance();
    for (int i = 0; i < N; i++) begin
      if (e_ack[i]) begin
        seq[i]++;
        req[i] = 1'b0;
        if (keep[i]) present(i, last[i]);
      end
    end
    if (rnd) begin
      wfull = ($urandom_range(3) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(1) == 1) present(i, $urandom_range(3) == 0);
        end else if (!e_ack[i] && $urandom_range(31) == 0) withdraw(i);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check();
    @(posedge clk);
    model_step();
    #1;
    advance();
  endtask

  task automatic do_reset();
    reset_b = 1'b0;
    #1;
    model_reset();
    check();
    chk("rst_busy", o_busy, 0);
    chk("rst_winc", o_winc, 0);
    chk("rst_ack", o_ack, 0);
    chk("rst_wdata", o_wdata, 0);
    req = '0; last = '0; data = '0; wfull = 1'b0; rnd = 1'b0;
    for (int i = 0; i < N; i++) begin
      keep[i] = 1'b0; q[i].delete(); seq[i] = '0; waitc[i] = 0;
    end
    cycle();
    cycle();
    reset_b = 1'b1;
    grants.delete();
  endtask

  initial begin
    int exp_g[5];
    exp_g = '{0, 1, 2, 3, 0};
    #2;
    do_reset();

    // two requesters held with single-word packets
    present(1, 1'b1); present(3, 1'b1); keep[1] = 1'b1; keep[3] = 1'b1;
    cycle();
    #2 chk("t1_owner", o_owner, 1); chk("t1_busy", o_busy, 1); chk("t1_ack", o_ack, 4'b0010);
    cycle();
    #2 chk("t1_idle", o_busy, 0);
    cycle();
    #2 chk("t1_owner3", o_owner, 3);
    cycle(); cycle();

    // all four requesting single-word packets: strict rotation
    do_reset();
    for (int i = 0; i < N; i++) begin keep[i] = 1'b1; present(i, 1'b1); end
    repeat (10) cycle();
    chk("t2_ngrants", grants.size(), 5);
    for (int i = 0; i < 5; i++) if (i < grants.size()) chk("t2_order", grants[i], exp_g[i]);

    // backpressure on owner 2
    do_reset();
    keep[2] = 1'b1; present(2, 1'b0);
    cycle();
    wfull = 1'b1;
    repeat (5) begin
      #2 chk("t3_nowinc", o_winc, 0); chk("t3_wdata", o_wdata, 8'h80);
      cycle();
    end
    wfull = 1'b0;
    repeat (3) begin
      #2 chk("t3_resume", o_winc, 1);
      cycle();
    end

    // forced release at MAXB, next arbitration moves on to requester 1
    do_reset();
    keep[0] = 1'b1; present(0, 1'b0); keep[1] = 1'b1; present(1, 1'b1);
    cycle();
    repeat (4) begin
      #2 chk("t4_winc", o_winc, 1); chk("t4_owner", o_owner, 0);
      cycle();
    end
    #2 chk("t4_overrun", o_overrun, 1); chk("t4_idle", o_busy, 0);
    cycle();
    #2 chk("t4_next", o_owner, 1); chk("t4_ovr_pulse", o_overrun, 0);

    // last coinciding with the MAXBth word is a normal end
    do_reset();
    keep[2] = 1'b1; present(2, 1'b0);
    cycle();
    repeat (3) cycle();
    last[2] = 1'b1;
    cycle();
    #2 chk("t5_no_overrun", o_overrun, 0); chk("t5_idle", o_busy, 0);

    // owner drops req mid-packet: lock holds, requester 1 stays blocked
    do_reset();
    present(0, 1'b0); keep[1] = 1'b1; present(1, 1'b1);
    cycle();
    cycle();
    repeat (3) begin
      #2 chk("t6_busy", o_busy, 1); chk("t6_owner", o_owner, 0); chk("t6_ack", o_ack, 0);
      cycle();
    end
    present(0, 1'b1);
    #2 chk("t6_resume", o_winc, 1);
    cycle();
    cycle();
    #2 chk("t6_next", o_owner, 1); chk("t6_busy2", o_busy, 1);

    // reset mid-packet while owner 3 holds the lock
    do_reset();
    keep[3] = 1'b1; present(3, 1'b0);
    cycle();
    cycle();
    #2 chk("t7_owner", o_owner, 3); chk("t7_busy", o_busy, 1);
    do_reset();
    present(0, 1'b1); present(3, 1'b1);
    cycle();
    #2 chk("t7_after", o_owner, 0);

    // random traffic
    do_reset();
    rnd = 1'b1;
    repeat (10000) cycle();
    rnd = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
